lfsr_sched: RTL
===============

# lfsr_sched

Two-requester scheduler that owns the 3-bit LFSR and shares it between two consumers. It arbitrates round-robin and steps the LFSR once per cycle for the granted burst length, streaming each value tagged with the requester id. It also provides an idle-time seed-load port with lock-up protection. It sits between the LFSR datapath and the blocks that consume pseudo-random values.

## Interface
- LEN_W, 4, width of burst-length inputs (bursts of 0..2^LEN_W-1 values)
- clk  in  1  rising-edge clock; the block's only clock
- set  in  1  reset; synchronous, active-high
- req  in  2  request per requester; req[i] high = requester i wants a burst
- len0  in  LEN_W  burst length for requester 0; sampled only at grant
- len1  in  LEN_W  burst length for requester 1; sampled only at grant
- seed_we  in  1  seed load strobe
- seed_in  in  3  seed value
- gnt  out  2  one-hot grant; 00 when idle
- busy  out  1  high whenever state is not IDLE
- out_valid  out  1  out_data carries a freshly stepped LFSR value
- out_data  out  3  LFSR state after the most recent step
- out_id  out  1  index of the granted requester; meaningful while gnt != 00
- done  out  1  one-cycle pulse marking the end of a burst
- seed_err  out  1  one-cycle pulse for a rejected seed write

## Operation
- LFSR step: Q_next = {Q[1:0], Q[2]^Q[1]}. Period is 7: 001→010→101→011→111→110→100→001. State 000 is never entered.
- FSM states are IDLE, RUN and DONE. All outputs are registered.
- IDLE, seed_we=1: seed_in≠000 loads the LFSR; seed_in=000 leaves the LFSR unchanged and pulses seed_err. A seed write takes priority over req in the same edge; the request waits.
- IDLE, any req with seed_we=0: pick the winner.
  - One requester asserting: that requester wins.
  - Both asserting: the requester not granted last time wins. The pointer `last` updates when a burst leaves DONE.
  - At the grant edge: set gnt to the winner's one-hot, out_id to the winner, cnt to the winner's len. Go to RUN if len≥1, or to DONE if len=0.
- RUN, each edge:
  - Step the LFSR, copy the new state to out_data, set out_valid=1, decrement cnt.
  - When cnt goes 1→0, set state to DONE and done=1 on that same edge, so done coincides with the last out_valid.
- DONE, next edge: clear gnt, out_valid and done, update `last`, return to IDLE. This gives at least one IDLE cycle between bursts.
- Other input rules:
  - req changes during RUN or DONE are ignored; the burst always completes.
  - A requester that keeps req high is re-arbitrated in IDLE.
  - seed_we outside IDLE is ignored and pulses seed_err.
- out_data holds its last value while out_valid=0. The LFSR keeps its state across bursts and is never reseeded implicitly.

## Timing
- Reset (set=1 at an edge) forces: state IDLE, LFSR=001, last=1 (requester 0 wins the first tie), gnt=00, busy=0, out_valid=0, out_data=000, out_id=0, done=0, seed_err=0, cnt=0.
- Reset during a burst aborts it: no done pulse, and the LFSR returns to 001.
- Request with req high at edge E0 in IDLE:
  - gnt and busy are high from E0.
  - out_valid is high after edges E1..E_len.
  - done is high after E_len.
  - gnt drops after E_len+1.
  - gnt is held for len+1 cycles.
- len=0: gnt, busy and done are high for 1 cycle after E0; out_valid stays 0 and the LFSR is unchanged.
- Latency from req to the first value is 2 edges. A burst occupies len+2 cycles including the mandatory IDLE cycle.
- seed_err is asserted the cycle after the offending seed_we edge, for exactly 1 cycle.

## Test plan
- Reset, then req=01 with len0=3 → out_data 010, 101, 011 with out_valid on 3 consecutive cycles, out_id=0, gnt=01 for 4 cycles, done on the 011 cycle.
- After reset, req0 with len0=7 → 010, 101, 011, 111, 110, 100, 001; the LFSR ends at 001.
- After reset, req=11 with len0=2 and len1=2 held → first burst id 0 (010, 101), one IDLE cycle, then id 1 (011, 111), then id 0 again.
- req=10 with len1=0 → a single-cycle gnt=10 with done=1, out_valid never high, and the next burst's first value continues from the prior LFSR state.
- seed_we with seed_in=000 → seed_err pulse and the next burst starts from 010. seed_we with seed_in=110 plus req0 in the same cycle with len0=2 → seed wins, then the burst yields 100, 001.
- set asserted on the 2nd value of a len0=5 burst → all outputs at reset values on the next cycle, no done, and the next burst's first value is 010.

Source files
------------

// File: rtl/lfsr_sched_if.sv
// Bus between the LFSR scheduler and its two pseudo-random value consumers.
// The scheduler uses the slave modport and the requesting side uses the master modport.
interface lfsr_sched_if #(
  parameter int LEN_W = 4
);
  logic [1:0]       req;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic             seed_we;
  logic [2:0]       seed_in;
  logic [1:0]       gnt;
  logic             busy;
  logic             out_valid;
  logic [2:0]       out_data;
  logic             out_id;
  logic             done;
  logic             seed_err;

  modport slave (
    input  req, len0, len1, seed_we, seed_in,
    output gnt, busy, out_valid, out_data, out_id, done, seed_err
  );

  modport master (
    output req, len0, len1, seed_we, seed_in,
    input  gnt, busy, out_valid, out_data, out_id, done, seed_err
  );
endinterface

// File: rtl/lfsr_sched.sv
// Round-robin scheduler that owns a 3-bit maximal LFSR and streams bursts of
// stepped values to two requesters, with an idle-only seed port that refuses the lock-up state.
module lfsr_sched #(
  parameter int LEN_W = 4
) (
  input  logic clk,
  input  logic set,
  lfsr_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [2:0]       r_lfsr;
  logic             r_last;
  logic [LEN_W-1:0] r_cnt;
  logic [1:0]       r_gnt;
  logic             r_busy;
  logic             r_out_valid;
  logic [2:0]       r_out_data;
  logic             r_out_id;
  logic             r_done;
  logic             r_seed_err;

  logic             w_pick;
  logic [LEN_W-1:0] w_len;
  logic [2:0]       w_lfsr_next;

  function automatic logic [2:0] lfsr_step(input logic [2:0] q);
    return {q[1:0], q[2] ^ q[1]};
  endfunction

  assign w_lfsr_next = lfsr_step(r_lfsr);

  // Winner selection: on a tie the requester not served last time wins.
  always_comb begin
    w_pick = 1'b0;
    w_len  = {LEN_W{1'b0}};
    case (bus.req)
      2'b01:   w_pick = 1'b0;
      2'b10:   w_pick = 1'b1;
      2'b11:   w_pick = ~r_last;
      default: w_pick = 1'b0;
    endcase
    if (w_pick) begin
      w_len = bus.len1;
    end else begin
      w_len = bus.len0;
    end
  end

  // Scheduler FSM, LFSR and all registered outputs.
  always_ff @(posedge clk) begin
    if (set) begin
      r_state     <= S_IDLE;
      r_lfsr      <= 3'b001;
      r_last      <= 1'b1;
      r_cnt       <= {LEN_W{1'b0}};
      r_gnt       <= 2'b00;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= 3'b000;
      r_out_id    <= 1'b0;
      r_done      <= 1'b0;
      r_seed_err  <= 1'b0;
    end else begin
      r_seed_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.seed_we) begin
            // Seed 000 would lock the LFSR up, so it is refused.
            if (bus.seed_in != 3'b000) begin
              r_lfsr <= bus.seed_in;
            end else begin
              r_seed_err <= 1'b1;
            end
          end else if (bus.req != 2'b00) begin
            r_gnt    <= w_pick ? 2'b10 : 2'b01;
            r_out_id <= w_pick;
            r_cnt    <= w_len;
            r_busy   <= 1'b1;
            if (w_len != {LEN_W{1'b0}}) begin
              r_state <= S_RUN;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_seed_err  <= bus.seed_we;
          r_lfsr      <= w_lfsr_next;
          r_out_data  <= w_lfsr_next;
          r_out_valid <= 1'b1;
          r_cnt       <= r_cnt - LEN_W'(1);
          if (r_cnt == LEN_W'(1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_DONE: begin
          r_seed_err  <= bus.seed_we;
          r_gnt       <= 2'b00;
          r_out_valid <= 1'b0;
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_last      <= r_out_id;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state     <= S_IDLE;
          r_gnt       <= 2'b00;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.busy      = r_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_id    = r_out_id;
  assign bus.done      = r_done;
  assign bus.seed_err  = r_seed_err;

endmodule
